// File: rtl/ext_pipe.sv
// ext_pipe: two-stage pipelined immediate / load-data extension unit.
//
// Immediate formation (zero, sign, upper placement) and sub-word load
// alignment (byte/halfword, signed/unsigned) share one datapath. Both
// stages use a valid/ready handshake with a synchronous flush.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   flush      synchronous drop of every in-flight and presented item
//   in_valid   input item present
//   in_ready   unit accepts the item this cycle (combinational)
//   in_op      0 ZIMM, 1 SIMM, 2 UIMM, 3 LB, 4 LBU, 5 LH, 6 LHU, 7 WORD
//   in_data    immediate in the low IMM_W bits, or the raw memory word
//   in_boff    byte offset for load ops
//   in_tag     sideband tag carried unchanged
//   out_valid  result present (S2 valid)
//   out_ready  consumer accepts the result
//   out_data   extended result
//   out_tag    tag of the result
//   out_err    misaligned halfword access flag
module ext_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 5,
    localparam int OFF_W = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFF_W-1:0]  in_boff,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err
);

    localparam logic [2:0] OP_ZIMM = 3'd0;
    localparam logic [2:0] OP_SIMM = 3'd1;
    localparam logic [2:0] OP_UIMM = 3'd2;
    localparam logic [2:0] OP_LB   = 3'd3;
    localparam logic [2:0] OP_LBU  = 3'd4;
    localparam logic [2:0] OP_LH   = 3'd5;
    localparam logic [2:0] OP_LHU  = 3'd6;

    // Extension class kept in S1: tells S2 how wide the stored field is
    // and how to fill the remaining bits.
    typedef enum logic [2:0] {
        CLS_ZIMM = 3'd0,
        CLS_SIMM = 3'd1,
        CLS_UIMM = 3'd2,
        CLS_S8   = 3'd3,
        CLS_Z8   = 3'd4,
        CLS_S16  = 3'd5,
        CLS_Z16  = 3'd6,
        CLS_WORD = 3'd7
    } ext_cls_e;

    function automatic logic [DATA_W-1:0] sext8(input logic [7:0] v);
        return {{(DATA_W-8){v[7]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext8(input logic [7:0] v);
        return {{(DATA_W-8){1'b0}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
        return {{(DATA_W-16){1'b0}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){v[IMM_W-1]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext_imm(input logic [IMM_W-1:0] v);
        return {{(DATA_W-IMM_W){1'b0}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] upper_imm(input logic [IMM_W-1:0] v);
        return {v, {(DATA_W-IMM_W){1'b0}}};
    endfunction

    // Stage 1 registers
    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_field_q, s1_field_d;
    ext_cls_e          s1_cls_q,   s1_cls_d;
    logic              s1_err_q,   s1_err_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;

    // Stage 2 registers (drive the outputs directly)
    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;
    logic              s2_err_q,   s2_err_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;

    logic              s1_adv_s;
    logic              s2_adv_s;
    logic              in_fire_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [DATA_W-1:0] ext_s;

    // Handshake: a stage may advance when it is empty or its successor advances.
    always_comb begin
        s2_adv_s  = !s2_valid_q || out_ready;
        s1_adv_s  = !s1_valid_q || s2_adv_s;
        in_ready  = s1_adv_s && !flush;
        in_fire_s = in_valid && in_ready;
    end

    // Sub-word extraction; the index width equals log2(DATA_W) exactly.
    always_comb begin
        byte_s = in_data[{in_boff, 3'b000} +: 8];
        half_s = in_data[{in_boff[OFF_W-1:1], 4'b0000} +: 16];
    end

    // Stage 1 next state: decode the op into a raw field plus extension class.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_field_d = s1_field_q;
        s1_cls_d   = s1_cls_q;
        s1_err_d   = s1_err_q;
        s1_tag_d   = s1_tag_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_d = in_fire_s;
            if (in_fire_s) begin
                s1_tag_d = in_tag;
                s1_err_d = 1'b0;
                case (in_op)
                    OP_ZIMM: begin
                        s1_field_d = zext_imm(in_data[IMM_W-1:0]);
                        s1_cls_d   = CLS_ZIMM;
                    end
                    OP_SIMM: begin
                        s1_field_d = zext_imm(in_data[IMM_W-1:0]);
                        s1_cls_d   = CLS_SIMM;
                    end
                    OP_UIMM: begin
                        s1_field_d = zext_imm(in_data[IMM_W-1:0]);
                        s1_cls_d   = CLS_UIMM;
                    end
                    OP_LB: begin
                        s1_field_d = zext8(byte_s);
                        s1_cls_d   = CLS_S8;
                    end
                    OP_LBU: begin
                        s1_field_d = zext8(byte_s);
                        s1_cls_d   = CLS_Z8;
                    end
                    OP_LH, OP_LHU: begin
                        // Odd offset: the item still flows, but as a zero
                        // result flagged with err.
                        if (in_boff[0]) begin
                            s1_field_d = {DATA_W{1'b0}};
                            s1_cls_d   = CLS_Z16;
                            s1_err_d   = 1'b1;
                        end else begin
                            s1_field_d = zext16(half_s);
                            s1_cls_d   = (in_op == OP_LH) ? CLS_S16 : CLS_Z16;
                        end
                    end
                    default: begin
                        s1_field_d = in_data;
                        s1_cls_d   = CLS_WORD;
                    end
                endcase
            end else begin
                s1_tag_d = s1_tag_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Final extension of the stored field according to its class.
    always_comb begin
        case (s1_cls_q)
            CLS_ZIMM: ext_s = zext_imm(s1_field_q[IMM_W-1:0]);
            CLS_SIMM: ext_s = sext_imm(s1_field_q[IMM_W-1:0]);
            CLS_UIMM: ext_s = upper_imm(s1_field_q[IMM_W-1:0]);
            CLS_S8:   ext_s = sext8(s1_field_q[7:0]);
            CLS_Z8:   ext_s = zext8(s1_field_q[7:0]);
            CLS_S16:  ext_s = sext16(s1_field_q[15:0]);
            CLS_Z16:  ext_s = zext16(s1_field_q[15:0]);
            default:  ext_s = s1_field_q;
        endcase
    end

    // Stage 2 next state: data only moves on an advance that carries an item,
    // so a stalled output holds bit-for-bit.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_err_d   = s2_err_q;
        s2_tag_d   = s2_tag_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d = ext_s;
                s2_err_d  = s1_err_q;
                s2_tag_d  = s1_tag_q;
            end else begin
                s2_data_d = s2_data_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 1 state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_field_q <= {DATA_W{1'b0}};
            s1_cls_q   <= CLS_ZIMM;
            s1_err_q   <= 1'b0;
            s1_tag_q   <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_field_q <= s1_field_d;
            s1_cls_q   <= s1_cls_d;
            s1_err_q   <= s1_err_d;
            s1_tag_q   <= s1_tag_d;
        end
    end

    // Stage 2 state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= {DATA_W{1'b0}};
            s2_err_q   <= 1'b0;
            s2_tag_q   <= {TAG_W{1'b0}};
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_err_q   <= s2_err_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign out_err   = s2_err_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Bench for ext_pipe: a 32-bit and a 64-bit instance share handshake and
// control stimulus, so both must show identical timing. Expected results
// come from an arithmetic reference and a queue model of the two-item pipe.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [2:0]  in_op;
    logic [63:0] in_data;
    logic [2:0]  in_boff;
    logic [4:0]  in_tag;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_data32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_data64;
    logic [4:0]  out_tag64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ext_pipe #(.DATA_W(32), .IMM_W(16), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_op(in_op),
        .in_data(in_data[31:0]), .in_boff(in_boff[1:0]), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_data(out_data32),
        .out_tag(out_tag32), .out_err(out_err32)
    );

    ext_pipe #(.DATA_W(64), .IMM_W(16), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_op(in_op),
        .in_data(in_data), .in_boff(in_boff), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension: returns {err, result} for a word width w.
    function automatic logic [64:0] ref_ext(input logic [2:0] op, input logic [63:0] d,
                                            input int boff, input int w);
        logic [63:0] m, r, imm, b, h;
        logic        err;
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        imm = d & 64'hFFFF;
        b   = (d >> (8 * boff)) & 64'hFF;
        h   = (d >> (16 * (boff / 2))) & 64'hFFFF;
        err = 1'b0;
        case (op)
            3'd0: r = imm;
            3'd1: r = (imm >= 64'h8000) ? imm - 64'h10000 : imm;
            3'd2: r = imm << (w - 16);
            3'd3: r = (b >= 64'd128) ? b - 64'd256 : b;
            3'd4: r = b;
            3'd5, 3'd6: begin
                if ((boff % 2) != 0) begin
                    r   = 64'd0;
                    err = 1'b1;
                end else begin
                    r = (op == 3'd5 && h >= 64'h8000) ? h - 64'h10000 : h;
                end
            end
            default: r = d;
        endcase
        return {err, r & m};
    endfunction

    typedef struct {
        logic [4:0]  tag;
        logic [63:0] e32;
        logic [63:0] e64;
        logic        err;
        logic        ripe;
        logic        has_lit;
        logic [63:0] l32;
        logic [63:0] l64;
        logic        lerr;
    } item_t;

    item_t q[$];
    int    xfer_tag[$];
    int    xfer_cyc[$];
    int    cyc = 0;
    bit    seen9 = 1'b0;

    logic        lit_on = 1'b0;
    logic [63:0] lit32, lit64;
    logic        literr;

    bit          m_fire, m_pop;
    item_t       m_h, m_it;
    logic [64:0] m_r32, m_r64;

    // Pipe model: items leave in order; an item becomes visible one edge
    // after it is accepted, once everything ahead of it has left.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                q.delete();
            end else begin
                cyc++;
                if (out_valid64 && out_ready) begin
                    xfer_tag.push_back(int'(out_tag64));
                    xfer_cyc.push_back(cyc);
                    if (out_tag64 == 5'd9) seen9 = 1'b1;
                end
                m_fire = in_valid && !flush && (q.size() < 2 || out_ready);
                m_pop  = q.size() > 0 && q[0].ripe && out_ready;
                if (flush) begin
                    q.delete();
                end else begin
                    if (m_pop) void'(q.pop_front());
                    if (q.size() > 0) begin
                        m_h      = q[0];
                        m_h.ripe = 1'b1;
                        q[0]     = m_h;
                    end
                    if (m_fire) begin
                        m_r32 = ref_ext(in_op, in_data & 64'h0000_0000_FFFF_FFFF, int'(in_boff) % 4, 32);
                        m_r64 = ref_ext(in_op, in_data, int'(in_boff), 64);
                        m_it.tag     = in_tag;
                        m_it.e32     = m_r32[63:0];
                        m_it.e64     = m_r64[63:0];
                        m_it.err     = m_r64[64];
                        m_it.ripe    = 1'b0;
                        m_it.has_lit = lit_on;
                        m_it.l32     = lit32;
                        m_it.l64     = lit64;
                        m_it.lerr    = literr;
                        q.push_back(m_it);
                    end
                end
            end
        end
    end

    bit          stall_prev = 1'b0;
    logic [63:0] sv_data64;
    logic [31:0] sv_data32;
    logic [4:0]  sv_tag;
    logic        sv_err;
    bit          c_ov, c_ir;

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                c_ov = q.size() > 0 && q[0].ripe;
                c_ir = !flush && (q.size() < 2 || out_ready);
                chk("out_valid32", out_valid32, c_ov);
                chk("out_valid64", out_valid64, c_ov);
                chk("in_ready32", in_ready32, c_ir);
                chk("in_ready64", in_ready64, c_ir);
                if (c_ov) begin
                    chk("data32", out_data32, q[0].e32);
                    chk("data64", out_data64, q[0].e64);
                    chk("tag32", out_tag32, q[0].tag);
                    chk("tag64", out_tag64, q[0].tag);
                    chk("err32", out_err32, q[0].err);
                    chk("err64", out_err64, q[0].err);
                    if (q[0].has_lit) begin
                        chk("lit_data32", out_data32, q[0].l32);
                        chk("lit_data64", out_data64, q[0].l64);
                        chk("lit_err", out_err64, q[0].lerr);
                    end
                end
                if (stall_prev) begin
                    chk("stall_data32", out_data32, sv_data32);
                    chk("stall_data64", out_data64, sv_data64);
                    chk("stall_tag", out_tag64, sv_tag);
                    chk("stall_err", out_err64, sv_err);
                end
                stall_prev = out_valid64 && !out_ready;
                sv_data32  = out_data32;
                sv_data64  = out_data64;
                sv_tag     = out_tag64;
                sv_err     = out_err64;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    // Present one item and hold it until accepted (bounded).
    task automatic push(input logic [2:0] op, input logic [63:0] d, input logic [2:0] b,
                        input logic [4:0] t);
        bit acc = 1'b0;
        in_valid = 1'b1; in_op = op; in_data = d; in_boff = b; in_tag = t;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready64;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        lit_on   = 1'b0;
        chk("accept_timeout", acc, 1'b1);
    endtask

    // One item into an empty pipe with literal expectations and latency check.
    task automatic directed(input logic [2:0] op, input logic [63:0] d, input logic [2:0] b,
                            input logic [4:0] t, input logic [63:0] l32, input logic [63:0] l64,
                            input logic le);
        out_ready = 1'b1;
        lit_on = 1'b1; lit32 = l32; lit64 = l64; literr = le;
        push(op, d, b, t);
        @(negedge clk);
        chk("latency_s1", out_valid64, 1'b0);
        @(negedge clk);
        chk("latency_s2", out_valid64, 1'b1);
        chk("latency_tag", out_tag64, t);
        @(posedge clk); #1;
    endtask

    localparam logic [63:0] IMMD = 64'hDEAD_BEEF_ABCD_8001;
    localparam logic [63:0] LDD  = 64'hC37E_5A01_80FF_7F01;

    initial begin
        bit acc;
        int accepts;
        int cur;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_data = 64'd0; in_boff = 3'd0; in_tag = 5'd0;
        #3;
        chk("rst_out_valid", out_valid64, 1'b0);
        chk("rst_out_data32", out_data32, 32'd0);
        chk("rst_out_data64", out_data64, 64'd0);
        chk("rst_out_tag", out_tag32, 5'd0);
        chk("rst_out_err", out_err32, 1'b0);
        #9 reset = 1'b0;
        #1 chk("rst_in_ready", in_ready32, 1'b1);
        @(posedge clk); #1;

        // Immediates and loads, literal results
        directed(3'd1, IMMD, 3'd0, 5'd1, 64'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
        directed(3'd0, IMMD, 3'd0, 5'd2, 64'h0000_8001, 64'h0000_0000_0000_8001, 1'b0);
        directed(3'd2, IMMD, 3'd0, 5'd3, 64'h8001_0000, 64'h8001_0000_0000_0000, 1'b0);
        directed(3'd3, LDD, 3'd0, 5'd4, 64'h0000_0001, 64'h1, 1'b0);
        directed(3'd3, LDD, 3'd1, 5'd5, 64'h0000_007F, 64'h7F, 1'b0);
        directed(3'd3, LDD, 3'd2, 5'd6, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed(3'd3, LDD, 3'd3, 5'd7, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
        directed(3'd4, LDD, 3'd3, 5'd8, 64'h0000_0080, 64'h80, 1'b0);
        directed(3'd5, LDD, 3'd2, 5'd10, 64'hFFFF_80FF, 64'hFFFF_FFFF_FFFF_80FF, 1'b0);
        directed(3'd6, LDD, 3'd2, 5'd11, 64'h0000_80FF, 64'h80FF, 1'b0);
        directed(3'd5, LDD, 3'd1, 5'd21, 64'h0, 64'h0, 1'b1);
        directed(3'd3, LDD, 3'd7, 5'd12, 64'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FFC3, 1'b0);
        directed(3'd4, LDD, 3'd7, 5'd13, 64'h0000_0080, 64'hC3, 1'b0);
        directed(3'd5, LDD, 3'd6, 5'd14, 64'hFFFF_80FF, 64'hFFFF_FFFF_FFFF_C37E, 1'b0);
        directed(3'd6, LDD, 3'd6, 5'd15, 64'h0000_80FF, 64'hC37E, 1'b0);
        directed(3'd7, LDD, 3'd5, 5'd16, 64'h80FF_7F01, LDD, 1'b0);

        // Backpressure: only two items fit while the output is stalled
        out_ready = 1'b0;
        xfer_tag.delete(); xfer_cyc.delete();
        cur = 1; accepts = 0;
        in_valid = 1'b1; in_op = 3'd7; in_data = {$urandom(), $urandom()}; in_tag = 5'd1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); acc = in_ready64 && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                accepts++;
                cur++;
                in_tag = 5'(cur); in_data = {$urandom(), $urandom()};
            end
        end
        chk("bp_accepts", accepts, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 30 && xfer_tag.size() < 4; i++) begin
            @(negedge clk); acc = in_ready64 && in_valid;
            @(posedge clk); #1;
            if (acc) begin
                if (cur == 4) in_valid = 1'b0;
                else begin
                    cur++;
                    in_tag = 5'(cur); in_data = {$urandom(), $urandom()};
                end
            end
        end
        in_valid = 1'b0;
        chk("bp_count", xfer_tag.size(), 4);
        for (int i = 0; i < 4 && i < xfer_tag.size(); i++) begin
            chk("bp_order", xfer_tag[i], i + 1);
            if (i > 0) chk("bp_gap", xfer_cyc[i] - xfer_cyc[i-1], 1);
        end

        // Flush with two items in flight while tag 9 is presented
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        seen9 = 1'b0;
        push(3'd4, LDD, 3'd1, 5'd7);
        push(3'd4, LDD, 3'd2, 5'd8);
        flush = 1'b1; in_valid = 1'b1; in_op = 3'd0; in_data = IMMD; in_tag = 5'd9;
        @(negedge clk);
        chk("flush_in_ready", in_ready64, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid32, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("flush_tag9_dropped", seen9, 1'b0);
        directed(3'd1, IMMD, 3'd0, 5'd17, 64'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 1'b0);

        // Asynchronous reset between edges with the pipe full
        out_ready = 1'b0;
        push(3'd7, LDD, 3'd0, 5'd11);
        push(3'd7, LDD, 3'd0, 5'd12);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid32", out_valid32, 1'b0);
        chk("arst_out_valid64", out_valid64, 1'b0);
        chk("arst_out_data64", out_data64, 64'd0);
        chk("arst_out_data32", out_data32, 32'd0);
        chk("arst_out_tag", out_tag64, 5'd0);
        #1 reset = 1'b0;
        stall_prev = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_op     = 3'($urandom_range(0, 7));
            in_data   = {$urandom(), $urandom()};
            in_boff   = 3'($urandom_range(0, 7));
            in_tag    = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
# ext_pipe

Parametrised, two-stage pipelined immediate/load-data extension unit with a valid/ready handshake. It generalises the combinational zero/sign extender into one block that serves both roles in the CPU datapath:
- immediate formation for ALU operands: zero, sign and upper-placement (lui);
- sub-word load alignment and extension after data memory: byte/halfword, signed/unsigned.

Its stall and flush controls let it sit directly between pipeline stages.

## Interface
Parameters:
- `DATA_W`, 32: word width; legal values 32 or 64.
- `IMM_W`, 16: immediate field width; must satisfy `IMM_W <= DATA_W/2`.
- `TAG_W`, 5: sideband tag width (destination register number), carried unchanged.
- Derived `OFF_W = $clog2(DATA_W/8)`: byte-offset width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `flush` in 1: synchronous; drops all in-flight and presented items.
- `in_valid` in 1: input item present.
- `in_ready` out 1: unit accepts the item this cycle.
- `in_op` in 3: operation select (see Operation).
- `in_data` in DATA_W: immediate in low IMM_W bits, or the raw memory word.
- `in_boff` in OFF_W: byte offset for load ops; ignored otherwise.
- `in_tag` in TAG_W: sideband tag.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out DATA_W: extended result.
- `out_tag` out TAG_W: tag of the result.
- `out_err` out 1: misaligned halfword access.

## Operation
Ops:
- 0 ZIMM: `{0, in_data[IMM_W-1:0]}`.
- 1 SIMM: sign-extend `in_data[IMM_W-1:0]`.
- 2 UIMM: `in_data[IMM_W-1:0]` in the top IMM_W bits, zeros below.
- 3 LB / 4 LBU: byte `in_data[8*boff +: 8]`, sign- or zero-extended.
- 5 LH / 6 LHU: halfword `in_data[16*boff[OFF_W-1:1] +: 16]`, sign- or zero-extended.
- 7 WORD: pass-through.

Misalignment:
- LH/LHU with `boff[0]=1` is misaligned.
- The result has `out_data = 0` and `out_err = 1`.
- The item still flows and is still counted as a normal item.
- `out_err = 0` for every other case.

Stages:
- S1 register holds the extracted field (up to 16 bits, or the full word), extension class, err flag and tag.
- S2 register holds the final extended word, err flag and tag.
- `out_*` are driven directly from S2.

Handshake:
- `s2_adv = !s2_valid | out_ready`.
- `s1_adv = !s1_valid | s2_adv`.
- `in_ready = s1_adv & !flush`, purely combinational.
- Input transfer occurs when `in_valid & in_ready`.
- Output transfer occurs when `out_valid & out_ready`.

Register updates:
- A stage register loads only when its stage advances.
- When a stage does not advance, its data and tag hold bit-for-bit (stall).
- `s1_valid` next state: `in_valid & in_ready` when S1 advances, else held.
- `s2_valid` next state: `s1_valid` when S2 advances, else held.

Flush:
- Takes priority over every other event.
- The next edge clears `s1_valid` and `s2_valid`.
- `in_ready = 0` during the flush cycle, so an item presented in that cycle is not accepted.
- Data registers are not required to clear.

Reset:
- `s1_valid`, `s2_valid`, `out_valid`, `out_err` = 0.
- `out_data` = 0, `out_tag` = 0, all S1 fields = 0.
- After release with `flush = 0`, `in_ready = 1`.

## Timing
- Latency: an item accepted at edge N appears on `out_*` after edge N+1 (2 edges), when no stall occurs.
- Throughput: 1 item/cycle while `out_ready = 1`.
- Full stall:
  - `out_ready = 0` with both stages valid gives `in_ready = 0`.
  - Capacity is exactly 2 items. No item is lost or duplicated.
- Bubble collapse: with S2 stalled and S1 empty, one more item is accepted into S1.
- Simultaneous output transfer and input transfer in the same cycle is legal: both stages shift.
- Reset asserted mid-operation: all valids drop asynchronously, and there is no output transfer until a new item is accepted.
- `out_data`, `out_tag` and `out_err` must not change while `out_valid & !out_ready`.

## Test plan
- Immediate ops, DATA_W=32, `in_data=0x0000_8001`, `out_ready=1`:
  - op1 gives `0xFFFF8001`; op0 gives `0x00008001`; op2 gives `0x80010000`.
  - Each result appears 2 edges after acceptance.
- Loads on `in_data=0x80FF7F01`:
  - LB: boff 0 → `0x00000001`; 1 → `0x0000007F`; 2 → `0xFFFFFFFF`; 3 → `0xFFFFFF80`.
  - LBU boff 3 → `0x00000080`.
  - LH boff 2 → `0xFFFF80FF`; LHU boff 2 → `0x000080FF`.
- Misaligned: LH with boff 1 → `out_data = 0`, `out_err = 1`, tag preserved.
- Backpressure:
  - Stream 4 tagged items (tags 1–4) with `out_ready = 0`: `in_ready` falls after 2 accepts.
  - Raise `out_ready`: tags emerge in order 1, 2, 3, 4 with no gaps; outputs stay stable during the stall.
- Flush: with 2 items in flight, assert `flush` while presenting tag 9.
  - Next cycle `out_valid = 0`; tag 9 is never output.
  - The following item flows normally.
- Asynchronous reset pulse between clock edges with the pipeline full: `out_valid` drops immediately, and `out_data` and `out_tag` read 0.
- Run the load scenarios again at DATA_W=64 (OFF_W = 3), with byte and halfword extraction at boff = 7 and boff = 6.
